// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//
// Fetch sequencer. Owns the program counter and drives a single-outstanding
// instruction-memory request/grant/response handshake, arbitrates the trap,
// branch and jump redirect sources by fixed priority, and holds one fetched
// instruction in an output slot until decode takes it.
//
// Optional build macro: FETCH_PERF_EN adds the perf_fetch_cnt/perf_kill_cnt
// counter outputs. Without it those ports do not exist.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   stall                   decode not ready; a full slot is held while high
//   redir_{trap,br,j}_valid redirect requests, priority trap > br > j
//   redir_{trap,br,j}_pc    redirect targets (low two bits ignored)
//   imem_req/imem_addr      fetch request and word-aligned address
//   imem_gnt                request accepted this cycle
//   imem_rvalid/imem_rdata  response strobe and instruction word
//   inst_valid/inst/inst_pc output slot: full flag, instruction, its address
//   pc                      address of the next fetch to issue
//   perf_fetch_cnt          (FETCH_PERF_EN) instructions presented
//   perf_kill_cnt           (FETCH_PERF_EN) responses discarded
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | one cycle after reset release, no request
// REQ    | imem_req high with imem_addr = pc, waiting for imem_gnt
// WAIT   | one fetch outstanding, waiting for imem_rvalid
// HOLD   | response landed in the slot, waiting for decode to take it

module fetch_ctrl #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redir_trap_valid,
  input  logic [XLEN-1:0] redir_trap_pc,
  input  logic            redir_br_valid,
  input  logic [XLEN-1:0] redir_br_pc,
  input  logic            redir_j_valid,
  input  logic [XLEN-1:0] redir_j_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] req_addr_q;
  logic            kill_q, kill_next;
  logic            slot_next;

  logic            redir_any;
  logic [XLEN-1:0] redir_raw;
  logic [XLEN-1:0] redir_tgt;
  logic            gnt_take;
  logic            rsp_take;
  logic            rsp_present;
  logic            rsp_discard;

  // Redirect arbitration: only the winner's target is looked at.
  always_comb begin
    redir_any = redir_trap_valid | redir_br_valid | redir_j_valid;
    redir_raw = redir_j_pc;
    if (redir_trap_valid)    redir_raw = redir_trap_pc;
    else if (redir_br_valid) redir_raw = redir_br_pc;
    redir_tgt = redir_raw & ~XLEN'(3);
  end

  // gnt and rvalid only mean something in the state that expects them.
  assign gnt_take    = (state == S_REQ) && imem_gnt;
  assign rsp_take    = (state == S_WAIT) && imem_rvalid;
  // A redirect in the response cycle kills that response as well.
  assign rsp_present = rsp_take && !kill_q && !redir_any;
  assign rsp_discard = rsp_take && !rsp_present;

  always_comb begin
    slot_next = inst_valid;
    if (redir_any)                slot_next = 1'b0;
    else if (rsp_present)         slot_next = 1'b1;
    else if (inst_valid && !stall) slot_next = 1'b0;
  end

  always_comb begin
    pc_next = pc_q;
    if (redir_any)     pc_next = redir_tgt;
    else if (gnt_take) pc_next = pc_q + XLEN'(INST_BYTES);
  end

  // Next state. REQ is only entered with the slot empty at the next edge,
  // so a response can always be accepted and the slot never overflows.
  always_comb begin
    state_next = state;
    kill_next  = kill_q;
    unique case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_next = S_WAIT;
          // The granted fetch is for the old path if a redirect came with it.
          kill_next  = redir_any;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // Outstanding fetch is retired either way; a redirect in this
          // cycle has nothing left to kill.
          kill_next  = 1'b0;
          state_next = slot_next ? S_HOLD : S_REQ;
        end else if (redir_any) begin
          kill_next  = 1'b1;
        end
      end
      S_HOLD: begin
        if (!slot_next) state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pc_q       <= RESET_VEC;
      req_addr_q <= RESET_VEC;
      kill_q     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      kill_q     <= kill_next;
      inst_valid <= slot_next;
      if (gnt_take) req_addr_q <= pc_q;
      if (rsp_present) begin
        inst    <= imem_rdata;
        inst_pc <= req_addr_q;
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc_q;
  assign pc        = pc_q;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (rsp_present) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (rsp_discard) perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run, all
// checked against a transaction-level reference model (next fetch address,
// one outstanding fetch with a killed flag, one output slot).
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redir_trap_valid = 1'b0, redir_br_valid = 1'b0, redir_j_valid = 1'b0;
  logic [31:0] redir_trap_pc = '0, redir_br_pc = '0, redir_j_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc, pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_kill_cnt;
`endif

  fetch_ctrl #(.XLEN(32), .RESET_VEC(RESET_VEC), .INST_BYTES(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redir_trap_valid(redir_trap_valid), .redir_trap_pc(redir_trap_pc),
    .redir_br_valid(redir_br_valid), .redir_br_pc(redir_br_pc),
    .redir_j_valid(redir_j_valid), .redir_j_pc(redir_j_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc(pc)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // stimulus for the next step
  bit          d_stall, d_gnt, d_rvalid, d_trap, d_br, d_j;
  logic [31:0] d_trap_pc, d_br_pc, d_j_pc;

  // reference model
  logic [31:0] m_pc, m_out_addr, m_inst, m_inst_pc;
  bit          m_req, m_out, m_out_killed, m_slot;
  int unsigned m_fcnt, m_kcnt;
  logic [31:0] req_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC; m_req = 0; m_out = 0; m_out_killed = 0; m_slot = 0;
    m_out_addr = '0; m_inst = '0; m_inst_pc = '0; m_fcnt = 0; m_kcnt = 0;
  endtask

  task automatic clear_redir();
    d_trap = 0; d_br = 0; d_j = 0;
  endtask

  // Compare outputs against the model, apply stimulus across one rising
  // edge, then advance the model by the same rules.
  task automatic step();
    logic [31:0] rdata, tgt;
    bit rd, resp, grant, present;
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst_valid", inst_valid, m_slot);
    if (m_slot) begin
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_inst_pc);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
    chk("perf_kill_cnt", perf_kill_cnt, m_kcnt);
`endif
    if (imem_req && d_gnt) req_log.push_back(imem_addr);
    rdata = $urandom;
    stall = d_stall; imem_gnt = d_gnt; imem_rvalid = d_rvalid; imem_rdata = rdata;
    redir_trap_valid = d_trap; redir_trap_pc = d_trap_pc;
    redir_br_valid = d_br; redir_br_pc = d_br_pc;
    redir_j_valid = d_j; redir_j_pc = d_j_pc;
    @(posedge clk);
    rd = d_trap | d_br | d_j;
    tgt = d_trap ? d_trap_pc : (d_br ? d_br_pc : d_j_pc);
    tgt = {tgt[31:2], 2'b00};
    resp = m_out && d_rvalid;
    grant = m_req && d_gnt;
    present = resp && !m_out_killed && !rd;
    if (rd) m_slot = 0;
    else if (present) begin m_slot = 1; m_inst = rdata; m_inst_pc = m_out_addr; end
    else if (!d_stall) m_slot = 0;
    if (present) m_fcnt++;
    if (resp && !present) m_kcnt++;
    if (resp) m_out = 0;
    else if (m_out && rd) m_out_killed = 1;
    if (grant) begin m_out = 1; m_out_addr = m_pc; m_out_killed = rd; end
    if (rd) m_pc = tgt;
    else if (grant) m_pc = m_pc + 32'd4;
    // a new fetch is requested whenever nothing is in flight and the slot is empty
    m_req = !m_out && !m_slot;
    #1;
  endtask

  initial begin
    int n;
    logic [31:0] held_inst, held_pc;
    d_stall = 0; d_gnt = 0; d_rvalid = 0; clear_redir();
    d_trap_pc = '0; d_br_pc = '0; d_j_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, RESET_VEC);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    reset_n = 1'b1;

    // immediate grant, response one cycle later, no stall
    d_gnt = 1; d_rvalid = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) chk("first_valid_early", inst_valid, 0);
      if (i == 3) chk("first_valid", inst_valid, 1);
      if (i == 3) chk("first_inst_pc", inst_pc, 32'h0);
      step();
    end
    chk("seq_len", (req_log.size() >= 3) ? 1 : 0, 1);
    if (req_log.size() >= 3) begin
      chk("seq_addr0", req_log[0], 32'h0);
      chk("seq_addr1", req_log[1], 32'h4);
      chk("seq_addr2", req_log[2], 32'h8);
    end

    // stall holds the slot
    d_stall = 1;
    n = 0;
    while (!inst_valid && n < 10) begin step(); n++; end
    chk("stall_fill", inst_valid, 1);
    held_inst = inst; held_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst", inst, held_inst);
      chk("stall_inst_pc", inst_pc, held_pc);
      chk("stall_no_req", imem_req, 0);
    end
    d_stall = 0;
    step();
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, held_pc + 32'd4);

    // jump during WAIT kills the response
    d_rvalid = 0; d_gnt = 1;
    n = 0;
    while (!m_out && n < 10) begin step(); n++; end
    chk("wait_reached", m_out, 1);
    d_gnt = 0; d_j = 1; d_j_pc = 32'h200;
    step();
    clear_redir(); d_rvalid = 1;
    step();
    d_rvalid = 0;
    chk("kill_no_valid", inst_valid, 0);
    chk("kill_req", imem_req, 1);
    chk("kill_addr", imem_addr, 32'h200);

    // all three redirects at once, in REQ without grant
    d_trap = 1; d_trap_pc = 32'h100; d_br = 1; d_br_pc = 32'h300; d_j = 1; d_j_pc = 32'h400;
    step();
    clear_redir();
    chk("prio_addr", imem_addr, 32'h100);
    chk("prio_req", imem_req, 1);

    // unaligned branch target while ungranted
    d_br = 1; d_br_pc = 32'h203;
    step();
    clear_redir();
    chk("align_addr", imem_addr, 32'h200);

    // wraparound of the fetch address
    d_trap = 1; d_trap_pc = 32'hFFFF_FFFC;
    step();
    clear_redir();
    chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
    d_gnt = 1; step();
    d_gnt = 0; d_rvalid = 1; step();
    d_rvalid = 0;
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // reset mid-WAIT
    d_gnt = 1; step();
    d_gnt = 0;
    chk("rstw_wait", m_out, 1);
    reset_n = 1'b0;
    #1;
    chk("rstw_req", imem_req, 0);
    chk("rstw_addr", imem_addr, RESET_VEC);
    chk("rstw_valid", inst_valid, 0);
    chk("rstw_inst", inst, 0);
    chk("rstw_inst_pc", inst_pc, 0);
    imem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    d_rvalid = 1;
    step();
    d_rvalid = 0;
    step();
    chk("rstw_restart_req", imem_req, 1);
    chk("rstw_restart_addr", imem_addr, RESET_VEC);
    chk("rstw_ignored", inst_valid, 0);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      d_stall  = ($urandom_range(0, 9) < 4);
      d_gnt    = ($urandom_range(0, 1) == 1);
      d_rvalid = m_out ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
      d_trap   = ($urandom_range(0, 29) == 0);
      d_br     = ($urandom_range(0, 19) == 0);
      d_j      = ($urandom_range(0, 14) == 0);
      d_trap_pc = $urandom;
      d_br_pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
      d_j_pc    = $urandom;
      step();
    end
    d_stall = 0; d_gnt = 0; d_rvalid = 0; clear_redir();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch sequencer that owns the program counter and drives a single-outstanding instruction-memory request/grant/response handshake.
- Arbitrates three redirect sources (trap, branch, jump) by fixed priority and kills any in-flight fetch on a redirect.
- Holds one fetched instruction in an output slot until decode accepts it.
- Sits between the imem port and the decode stage.

Parameters:
- XLEN, 32, address/instruction width
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- INST_BYTES, 4, sequential PC increment

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  decode not ready; slot held while inst_valid && stall
- redir_trap_valid  in  1  trap redirect, highest priority
- redir_trap_pc  in  XLEN  trap target
- redir_br_valid  in  1  branch-mispredict redirect, middle priority
- redir_br_pc  in  XLEN  branch target
- redir_j_valid  in  1  jump redirect, lowest priority
- redir_j_pc  in  XLEN  jump target
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  XLEN  response instruction
- inst_valid  out  1  output slot full
- inst  out  XLEN  fetched instruction
- inst_pc  out  XLEN  address of inst
- pc  out  XLEN  address of the next fetch to issue

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_VEC; state = IDLE; kill = 0.
  - imem_req = 0, imem_addr = RESET_VEC, inst_valid = 0, inst = 0, inst_pc = 0.
- States:
  - IDLE: exactly one cycle after reset release; then REQ.
  - REQ: imem_req = 1, imem_addr = pc. On imem_gnt: pc <= pc + INST_BYTES (wraps mod 2^XLEN); go to WAIT.
  - WAIT: imem_req = 0, awaiting imem_rvalid.
- In WAIT, imem_rvalid with kill = 0:
  - inst <= imem_rdata, inst_pc <= the granted address, inst_valid <= 1.
- In WAIT, imem_rvalid with kill = 1:
  - Response is discarded and kill <= 0.
- Leaving WAIT on imem_rvalid:
  - Go to REQ if the slot is free next cycle, otherwise to HOLD.
- HOLD: imem_req = 0; go to REQ once the slot has been consumed.
- Slot consume: inst_valid && !stall clears inst_valid at the next edge, unless refilled by a response on the same edge.
- REQ gating: REQ is entered only when the slot is empty or being consumed that cycle, so the slot never overflows.
- Fetch latency: minimum 2 cycles from imem_req to inst_valid (grant cycle, then rvalid cycle, registered output).
- Redirect:
  - Winner = trap > br > j. Only the winner's target is used; the others are ignored that cycle with no memory of them.
  - Target low 2 bits are forced to 0.
  - Effects at the next edge: pc <= target; inst_valid <= 0.
  - State after a redirect:
    - In WAIT, or in REQ with imem_gnt high: kill <= 1, stay in/enter WAIT.
    - In REQ without imem_gnt: stay in REQ, and imem_addr shows the new target next cycle (address change while ungranted is permitted by the imem protocol).
    - In IDLE or HOLD: go to REQ.
- Redirect and imem_rvalid in the same cycle: the response is killed, never presented.
- Redirect while stall = 1: the slot is still flushed.
- Back-to-back redirects: last winner wins; kill stays 1 (a single flag covers the single outstanding fetch).
- imem_rvalid outside WAIT: ignored (protocol violation, no state change).
- imem_gnt outside REQ: ignored.
- Reset mid-transaction: all state clears immediately. Any later response is ignored because state = IDLE.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetch_cnt (32) and perf_kill_cnt (32), both reset to 0 and wrapping.
  - perf_fetch_cnt increments on each presented instruction.
  - perf_kill_cnt increments on each discarded response.
- When undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset release, imem grants immediately, rvalid 1 cycle later, stall = 0 -> imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches; first inst_valid 3 cycles after reset release.
- stall = 1 for 5 cycles with inst_valid = 1 -> inst/inst_pc frozen, imem_req = 0 (HOLD); fetch of next PC resumes on the cycle stall drops.
- redir_j_valid (0x200) during WAIT, response arrives next cycle -> response dropped, inst_valid stays 0, next imem_addr = 0x200.
- Trap (0x100), branch (0x300) and jump (0x400) asserted in the same cycle -> next imem_addr = 0x100.
- Branch target 0x203 while in REQ with gnt low -> imem_addr becomes 0x200 the next cycle.
- pc = 0xFFFF_FFFC granted -> next imem_addr = 0x0.
- Assert reset_n low mid-WAIT, then rvalid -> outputs cleared asynchronously, response ignored; restart from RESET_VEC.
